vga_timing_gen: RTL

Parametrised VGA raster timing generator with a one-stage pixel pipeline. Programmable porch, sync and active lengths per axis; programmable sync polarity; clock-enable pixel divider; configurable RGB width. Sits between the system clock and the VGA DAC pins. Drives pixel coordinates to the frame renderer and registers the returned colour aligned with the sync outputs.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_axis_counter.sv | 40 ++++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Standard VGA raster timing sets, derived totals and sync-polarity constants
// shared by the timing generator and its axis counters.
package vga_timing_pkg;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    logic         hs_pol;
    logic         vs_pol;
  } vga_timing_t;

  function automatic int axis_total(axis_timing_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

  // Smallest counter width that can hold 0..total-1.
  function automatic int cnt_width(int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam vga_timing_t VGA_640x480_60 = '{
    h: '{640, 16, 96, 48},
    v: '{480, 10, 2, 33},
    hs_pol: SYNC_ACT_LOW,
    vs_pol: SYNC_ACT_LOW
  };

  localparam vga_timing_t VGA_800x600_60 = '{
    h: '{800, 40, 128, 88},
    v: '{600, 1, 4, 23},
    hs_pol: SYNC_ACT_HIGH,
    vs_pol: SYNC_ACT_HIGH
  };

  localparam int VGA_640x480_60_H_TOTAL = axis_total(VGA_640x480_60.h);
  localparam int VGA_640x480_60_V_TOTAL = axis_total(VGA_640x480_60.v);
  localparam int VGA_800x600_60_H_TOTAL = axis_total(VGA_800x600_60.h);
  localparam int VGA_800x600_60_V_TOTAL = axis_total(VGA_800x600_60.v);

endpackage

// File: rtl/vga_axis_counter.sv
// Generic raster axis counter: wraps at active+fp+sync+bp-1 and decodes the
// visible region and the (polarity-adjusted) sync level from the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = SYNC_ACT_LOW,
  parameter int   CW     = 10
) (
  input  logic          gclk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          active,
  output logic          sync_lvl
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] C_LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] C_ACT  = CW'(ACTIVE);
  localparam logic [CW-1:0] C_SS   = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] C_SE   = CW'(ACTIVE + FP + SYNC);

  always_ff @(posedge gclk or posedge rst)
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= last ? '0 : count + 1'b1;

  always_comb begin
    last     = (count == C_LAST);
    active   = (count < C_ACT);
    sync_lvl = (count >= C_SS && count < C_SE) ? POL : ~POL;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a one-pixel output pipeline that aligns the
// renderer's colour with sync/active. Optional border: VGA_TIMING_BORDER_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_640x480_60.h.active,
  parameter int   H_FP     = VGA_640x480_60.h.fp,
  parameter int   H_SYNC   = VGA_640x480_60.h.sync,
  parameter int   H_BP     = VGA_640x480_60.h.bp,
  parameter int   V_ACTIVE = VGA_640x480_60.v.active,
  parameter int   V_FP     = VGA_640x480_60.v.fp,
  parameter int   V_SYNC   = VGA_640x480_60.v.sync,
  parameter int   V_BP     = VGA_640x480_60.v.bp,
  parameter logic HS_POL   = VGA_640x480_60.hs_pol,
  parameter logic VS_POL   = VGA_640x480_60.vs_pol,
  parameter int   CLK_DIV  = 2,
  parameter int   RGB_W    = 3,
  parameter int   CW       = 10
`ifdef VGA_TIMING_BORDER_EN
  ,
  parameter int               BORDER_X   = 48,
  parameter int               BORDER_Y   = 32,
  parameter logic [RGB_W-1:0] BORDER_RGB = RGB_W'(3'b010)
`endif
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iEnable,
  input  logic [RGB_W-1:0] iRGB,
  output logic [CW-1:0]    Cont_X,
  output logic [CW-1:0]    Cont_Y,
  output logic             oPixelTick,
  output logic             oFrameStart,
  output logic             H_Sync,
  output logic             V_Sync,
  output logic             oActive,
  output logic [RGB_W-1:0] oRGB
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]    presc, presc_nxt;
  logic             x_last, y_last, x_act, y_act, hs_lvl, vs_lvl;
  logic [RGB_W-1:0] pix_rgb;

  always_comb presc_nxt = (presc == P_LAST) ? '0 : presc + 1'b1;

  // The tick is registered from the next prescaler value so it is high
  // exactly while the prescaler sits at CLK_DIV-1.
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      presc      <= '0;
      oPixelTick <= 1'b0;
    end else if (!iEnable) begin
      presc      <= '0;
      oPixelTick <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      oPixelTick <= (presc_nxt == P_LAST);
    end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_x (
    .gclk(Clock), .rst(Reset), .clr(!iEnable), .en(oPixelTick),
    .count(Cont_X), .last(x_last), .active(x_act), .sync_lvl(hs_lvl)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_y (
    .gclk(Clock), .rst(Reset), .clr(!iEnable), .en(oPixelTick && x_last),
    .count(Cont_Y), .last(y_last), .active(y_act), .sync_lvl(vs_lvl)
  );

`ifdef VGA_TIMING_BORDER_EN
  localparam logic [CW-1:0] BX_LO = CW'(BORDER_X);
  localparam logic [CW-1:0] BX_HI = CW'(H_ACTIVE - BORDER_X);
  localparam logic [CW-1:0] BY_LO = CW'(BORDER_Y);
  localparam logic [CW-1:0] BY_HI = CW'(V_ACTIVE - BORDER_Y);

  logic in_border;

  always_comb begin
    in_border = (Cont_X < BX_LO) || (Cont_X >= BX_HI) ||
                (Cont_Y < BY_LO) || (Cont_Y >= BY_HI);
    pix_rgb   = in_border ? BORDER_RGB : iRGB;
  end
`else
  always_comb pix_rgb = iRGB;
`endif

  // Pipeline stage: decode of the coordinate currently on Cont_X/Cont_Y,
  // captured on the tick that moves the counters on.
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      oFrameStart <= 1'b0;
      oActive     <= 1'b0;
      oRGB        <= '0;
      H_Sync      <= ~HS_POL;
      V_Sync      <= ~VS_POL;
    end else if (!iEnable) begin
      oFrameStart <= 1'b0;
      oActive     <= 1'b0;
      oRGB        <= '0;
      H_Sync      <= ~HS_POL;
      V_Sync      <= ~VS_POL;
    end else begin
      oFrameStart <= oPixelTick && x_last && y_last;
      if (oPixelTick) begin
        oActive <= x_act && y_act;
        oRGB    <= (x_act && y_act) ? pix_rgb : '0;
        H_Sync  <= hs_lvl;
        V_Sync  <= vs_lvl;
      end
    end

endmodule
